gelato_warp_alu_dispatcher: RTL and testbench
=============================================

Name: gelato_warp_alu_dispatcher

Overview:
- Slave end of the CU→ALU warp compute-task handshake.
- Accepts one warp-wide arithmetic task (op plus three per-thread operand vectors) from the compute unit.
- Splits the task into LANES-wide groups, which it issues in order to LANES scalar ALU slaves over the scalar ALU-task handshake.
- Collects the per-thread results into a warp result register and returns it with a one-cycle done pulse.

Parameters:
- THREAD_NUM, 32: threads per warp. Must be a multiple of LANES.
- LANES, 4: number of parallel scalar ALUs driven.
- DATA_WIDTH, 32: width of data_t.
- OP_WIDTH, 6: width of the arith_oper_t encoding. Opaque to this block.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- task_valid  in  1  CU task request; held high until task_done
- task_op  in  OP_WIDTH  arithmetic operation
- task_rs1  in  THREAD_NUM*DATA_WIDTH  operand A; thread t at [t*DATA_WIDTH +: DATA_WIDTH]
- task_rs2  in  THREAD_NUM*DATA_WIDTH  operand B, same packing
- task_rs3  in  THREAD_NUM*DATA_WIDTH  operand C, same packing
- task_done  out  1  one-cycle completion pulse
- task_rd  out  THREAD_NUM*DATA_WIDTH  warp result, same packing
- alu_valid  out  LANES  per-lane scalar request
- alu_op  out  OP_WIDTH  op shared by all lanes
- alu_rs1  out  LANES*DATA_WIDTH  lane l at [l*DATA_WIDTH +: DATA_WIDTH]
- alu_rs2  out  LANES*DATA_WIDTH  same packing
- alu_rs3  out  LANES*DATA_WIDTH  same packing
- alu_done  in  LANES  per-lane one-cycle completion pulse
- alu_rd  in  LANES*DATA_WIDTH  lane result; valid when the matching alu_done bit is high

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - State goes to IDLE; group index is 0.
  - task_done, task_rd, alu_valid, alu_op, alu_rs1/2/3, the latched operands and the lane_done sticky bits all clear to 0.
  - Reset mid-task discards the task with no done pulse; ALU done pulses arriving during reset are ignored.
- Groups: G = THREAD_NUM/LANES. Group g, lane l carries thread t = g*LANES + l.
- States are IDLE, RUN, NEXT and RESP.
- IDLE:
  - If task_valid is high, latch task_op and task_rs1/2/3 into internal registers, set group index to 0, clear lane_done and go to RUN.
  - Input operands are not used after this latch cycle.
- RUN:
  - alu_valid[l] = !lane_done[l]. alu_op comes from the latched op; alu_rs* come from the latched operands of group g.
  - When alu_done[l] is high and alu_valid[l] is high: write alu_rd lane l into task_rd slot t and set lane_done[l].
  - alu_done on a lane whose alu_valid is low is ignored.
  - Once every lane is finished (lane_done | qualified alu_done is all ones): go to RESP if g == G-1, else go to NEXT.
  - Lanes may finish in any order and in any cycles. There is no timeout.
- NEXT:
  - All alu_valid are low for exactly one cycle, so every ALU sees a valid edge per group.
  - Increment g, clear lane_done, return to RUN.
- RESP:
  - task_done is high for exactly this one cycle; task_rd holds the complete result, then go to IDLE.
  - task_rd holds its value until the next task writes it.
- Master rule: task_valid must be low in the cycle after task_done, unless it is presenting a new task. IDLE accepts a new task in that cycle, giving back-to-back operation.
- ALU slave rule: alu_done is registered, so its earliest assertion is the cycle after alu_valid rises.
- Latency with 1-cycle ALUs: task accepted at cycle T gives task_done at T+3G. Group k has RUN at T+1+3k, done at T+2+3k and NEXT at T+3+3k.
- No arithmetic is performed in this block. Data passes bit-exact; the op is never decoded.
- task_valid going high while in RUN, NEXT or RESP is ignored.

Test Plan:
- THREAD_NUM=4, LANES=2, 1-cycle ALU computing rs1+rs2. Stimulus: rs1={4,3,2,1}, rs2={40,30,20,10} (thread3..0), accept at cycle 0.
  - Required: RUN at cycles 1 and 4, alu_valid=0 at cycles 3 and 6, task_done only at cycle 6, task_rd={44,33,22,11}.
- Staggered lanes: in group 0, lane 1 finishes at cycle 2 and lane 0 at cycle 5.
  - Required: alu_valid[1] drops at cycle 3 while alu_valid[0] stays high through cycle 5; NEXT at cycle 6; results land in the correct slots.
- Spurious alu_done[0] pulse in IDLE and in NEXT.
  - Required: task_rd is unchanged and no state change occurs.
- Back-to-back tasks: task_valid is held high with new operands in the cycle after task_done.
  - Required: the new task is accepted that cycle; the second task_done follows 3G cycles later with the second result.
- rst asserted for one cycle at cycle 2 of a task.
  - Required: all outputs are 0 next cycle, no task_done is ever produced, and a new task then completes normally.
- task_rs1 changes after the accept cycle.
  - Required: alu_rs1 still reflects the latched operands, and the result matches the original values.

Source files
------------

// File: rtl/gelato_warp_alu_dispatcher.sv
// Warp-wide ALU task dispatcher: slices a latched warp task into LANES-wide groups,
// issues each group to the scalar ALUs and gathers the per-thread results.
module gelato_warp_alu_dispatcher #(
    parameter int unsigned THREAD_NUM = 32,
    parameter int unsigned LANES      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OP_WIDTH   = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             task_valid,
    input  logic [OP_WIDTH-1:0]              task_op,
    input  logic [THREAD_NUM*DATA_WIDTH-1:0] task_rs1,
    input  logic [THREAD_NUM*DATA_WIDTH-1:0] task_rs2,
    input  logic [THREAD_NUM*DATA_WIDTH-1:0] task_rs3,
    output logic                             task_done,
    output logic [THREAD_NUM*DATA_WIDTH-1:0] task_rd,
    output logic [LANES-1:0]                 alu_valid,
    output logic [OP_WIDTH-1:0]              alu_op,
    output logic [LANES*DATA_WIDTH-1:0]      alu_rs1,
    output logic [LANES*DATA_WIDTH-1:0]      alu_rs2,
    output logic [LANES*DATA_WIDTH-1:0]      alu_rs3,
    input  logic [LANES-1:0]                 alu_done,
    input  logic [LANES*DATA_WIDTH-1:0]      alu_rd
);
    localparam int unsigned GROUPS = THREAD_NUM / LANES;
    localparam int unsigned GRP_W  = LANES * DATA_WIDTH;
    localparam int unsigned WARP_W = THREAD_NUM * DATA_WIDTH;
    localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [GW-1:0] LAST_GROUP = GW'(GROUPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_NEXT,
        S_RESP
    } state_t;

    state_t              r_state;
    logic [GW-1:0]       r_group;
    logic [LANES-1:0]    r_lane_done;
    logic [LANES-1:0]    r_alu_valid;
    logic [OP_WIDTH-1:0] r_alu_op;
    logic [WARP_W-1:0]   r_rs1;
    logic [WARP_W-1:0]   r_rs2;
    logic [WARP_W-1:0]   r_rs3;
    logic [WARP_W-1:0]   r_task_rd;
    logic [GRP_W-1:0]    r_alu_rs1;
    logic [GRP_W-1:0]    r_alu_rs2;
    logic [GRP_W-1:0]    r_alu_rs3;
    logic                r_task_done;

    logic [LANES-1:0]    w_qual_done;
    logic                w_group_done;
    int unsigned         w_next_base;

    // A done pulse only counts on a lane that is still being requested.
    always_comb begin
        w_qual_done  = alu_done & r_alu_valid;
        w_group_done = &(r_lane_done | w_qual_done);
        w_next_base  = (32'(r_group) + 32'd1) * GRP_W;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_group     <= '0;
            r_lane_done <= '0;
            r_alu_valid <= '0;
            r_alu_op    <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rs3       <= '0;
            r_task_rd   <= '0;
            r_alu_rs1   <= '0;
            r_alu_rs2   <= '0;
            r_alu_rs3   <= '0;
            r_task_done <= 1'b0;
        end else begin
            r_task_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (task_valid) begin
                        r_rs1       <= task_rs1;
                        r_rs2       <= task_rs2;
                        r_rs3       <= task_rs3;
                        r_alu_op    <= task_op;
                        // Group 0 is driven straight from the inputs so the first request
                        // is already valid in the first RUN cycle.
                        r_alu_rs1   <= task_rs1[GRP_W-1:0];
                        r_alu_rs2   <= task_rs2[GRP_W-1:0];
                        r_alu_rs3   <= task_rs3[GRP_W-1:0];
                        r_group     <= '0;
                        r_lane_done <= '0;
                        r_alu_valid <= '1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int unsigned l = 0; l < LANES; l++) begin
                        if (w_qual_done[l]) begin
                            r_task_rd[(32'(r_group) * LANES + l) * DATA_WIDTH +: DATA_WIDTH]
                                <= alu_rd[l * DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    r_lane_done <= r_lane_done | w_qual_done;
                    if (w_group_done) begin
                        r_alu_valid <= '0;
                        if (r_group == LAST_GROUP) begin
                            r_task_done <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_state <= S_NEXT;
                        end
                    end else begin
                        r_alu_valid <= r_alu_valid & ~w_qual_done;
                    end
                end
                S_NEXT: begin
                    r_group     <= r_group + GW'(1);
                    r_lane_done <= '0;
                    r_alu_valid <= '1;
                    r_alu_rs1   <= r_rs1[w_next_base +: GRP_W];
                    r_alu_rs2   <= r_rs2[w_next_base +: GRP_W];
                    r_alu_rs3   <= r_rs3[w_next_base +: GRP_W];
                    r_state     <= S_RUN;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign task_done = r_task_done;
    assign task_rd   = r_task_rd;
    assign alu_valid = r_alu_valid;
    assign alu_op    = r_alu_op;
    assign alu_rs1   = r_alu_rs1;
    assign alu_rs2   = r_alu_rs2;
    assign alu_rs3   = r_alu_rs3;

endmodule

// File: tb/tb_gelato_warp_alu_dispatcher.sv
// Bench for gelato_warp_alu_dispatcher: table vectors, directed timing sequences and
// random tasks against a per-thread arithmetic model with variable-latency ALU slaves.
module tb_gelato_warp_alu_dispatcher;
    localparam int TN  = 4;
    localparam int LN  = 2;
    localparam int DW  = 32;
    localparam int OPW = 6;
    localparam int G   = TN / LN;
    localparam int WW  = TN * DW;
    localparam int LW  = LN * DW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           task_valid = 1'b0;
    logic [OPW-1:0] task_op = '0;
    logic [WW-1:0]  task_rs1 = '0;
    logic [WW-1:0]  task_rs2 = '0;
    logic [WW-1:0]  task_rs3 = '0;
    logic           task_done;
    logic [WW-1:0]  task_rd;
    logic [LN-1:0]  alu_valid;
    logic [OPW-1:0] alu_op;
    logic [LW-1:0]  alu_rs1;
    logic [LW-1:0]  alu_rs2;
    logic [LW-1:0]  alu_rs3;
    logic [LN-1:0]  alu_done;
    logic [LW-1:0]  alu_rd;

    gelato_warp_alu_dispatcher #(
        .THREAD_NUM(TN),
        .LANES(LN),
        .DATA_WIDTH(DW),
        .OP_WIDTH(OPW)
    ) dut (
        .clk(clk), .rst(rst),
        .task_valid(task_valid), .task_op(task_op),
        .task_rs1(task_rs1), .task_rs2(task_rs2), .task_rs3(task_rs3),
        .task_done(task_done), .task_rd(task_rd),
        .alu_valid(alu_valid), .alu_op(alu_op),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rs3(alu_rs3),
        .alu_done(alu_done), .alu_rd(alu_rd)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Scalar ALU slaves: answer once per rising valid, lat[l] cycles later, rs1+rs2+rs3+op.
    int            lat [LN];
    int            cnt [LN];
    logic [DW-1:0] res [LN];
    logic [LN-1:0] busy = '0;
    logic [LN-1:0] prev_v = '0;
    logic [LN-1:0] mdl_done = '0;
    logic [LW-1:0] mdl_rd = '0;
    logic [LN-1:0] spur = '0;

    always @(posedge clk) begin
        for (int l = 0; l < LN; l++) begin
            mdl_done[l] <= 1'b0;
            if (rst) begin
                busy[l] = 1'b0;
            end else begin
                if (alu_valid[l] && !prev_v[l]) begin
                    busy[l] = 1'b1;
                    cnt[l]  = lat[l];
                    res[l]  = alu_rs1[l*DW +: DW] + alu_rs2[l*DW +: DW] + alu_rs3[l*DW +: DW]
                              + DW'(alu_op);
                end
                if (busy[l]) begin
                    cnt[l] = cnt[l] - 1;
                    if (cnt[l] == 0) begin
                        busy[l] = 1'b0;
                        mdl_done[l] <= 1'b1;
                        mdl_rd[l*DW +: DW] <= res[l];
                    end
                end
            end
        end
        prev_v <= alu_valid;
    end

    assign alu_done = mdl_done | spur;
    always_comb begin
        alu_rd = mdl_rd;
        for (int l = 0; l < LN; l++)
            if (spur[l]) alu_rd[l*DW +: DW] = 32'hDEADBEEF;
    end

    typedef struct {
        logic [OPW-1:0] op;
        logic [WW-1:0]  rs1;
        logic [WW-1:0]  rs2;
        logic [WW-1:0]  rs3;
        int             l0;
        int             l1;
        logic [WW-1:0]  rd;
        int             cyc;
    } vec_t;

    vec_t          tbl [3];
    logic [LN-1:0] exp_va [6];
    logic [LN-1:0] exp_vb [6];
    logic [WW-1:0] orig;
    logic [WW-1:0] saved;
    int            cyc;
    logic          seen;

    function automatic logic [WW-1:0] p4(input logic [31:0] a3, a2, a1, a0);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [WW-1:0] rnd_warp();
        logic [WW-1:0] r;
        for (int t = 0; t < TN; t++) r[t*DW +: DW] = $urandom();
        return r;
    endfunction

    function automatic logic [WW-1:0] ref_rd(input logic [OPW-1:0] op,
                                             input logic [WW-1:0] a, b, c);
        logic [WW-1:0] r;
        for (int t = 0; t < TN; t++)
            r[t*DW +: DW] = a[t*DW +: DW] + b[t*DW +: DW] + c[t*DW +: DW] + DW'(op);
        return r;
    endfunction

    // Each group spends max(lat) cycles waiting plus one finishing RUN cycle and one NEXT/RESP.
    function automatic int ref_cycles();
        int m = 0;
        for (int l = 0; l < LN; l++) if (lat[l] > m) m = lat[l];
        return G * (m + 2);
    endfunction

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [OPW-1:0] op, input logic [WW-1:0] a, b, c);
        task_op    = op;
        task_rs1   = a;
        task_rs2   = b;
        task_rs3   = c;
        task_valid = 1'b1;
    endtask

    task automatic wait_done(input string name, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (task_done !== 1'b1 && n < 200);
        task_valid = 1'b0;
        if (task_done !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no task_done after %0d cycles, want a pulse", name, n);
        end
    endtask

    initial begin
        lat[0] = 1;
        lat[1] = 1;
        tbl[0] = '{6'd0, p4(4, 3, 2, 1), p4(40, 30, 20, 10), '0, 1, 1,
                   p4(44, 33, 22, 11), 6};
        tbl[1] = '{6'd1, p4(32'hFFFFFFFF, 7, 0, 32'h80000000), p4(1, 8, 0, 32'h80000000), '0,
                   4, 1, p4(1, 16, 1, 1), 12};
        tbl[2] = '{6'd5, p4(100, 200, 300, 400), p4(1, 2, 3, 4), p4(1000, 0, 0, 16), 2, 3,
                   p4(1106, 207, 308, 425), 10};
        exp_va = '{2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00};
        exp_vb = '{2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b00};

        step();
        step();
        check("rst_ctrl", {task_done, alu_valid, alu_op}, '0);
        check("rst_rd", task_rd, '0);
        check("rst_rs12", {alu_rs1, alu_rs2}, '0);
        check("rst_rs3", alu_rs3, '0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 3; i++) begin
            lat[0] = tbl[i].l0;
            lat[1] = tbl[i].l1;
            present(tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rs3);
            wait_done($sformatf("vec%0d", i), cyc);
            check($sformatf("vec%0d_cycles", i), cyc, tbl[i].cyc);
            check($sformatf("vec%0d_rd", i), task_rd, tbl[i].rd);
            step();
            check($sformatf("vec%0d_pulse", i), task_done, 0);
        end

        // Basic per-cycle trace with 1-cycle ALUs.
        lat[0] = 1;
        lat[1] = 1;
        present(0, p4(4, 3, 2, 1), p4(40, 30, 20, 10), '0);
        for (int c = 1; c <= 6; c++) begin
            step();
            check($sformatf("A_valid_c%0d", c), alu_valid, exp_va[c-1]);
            check($sformatf("A_done_c%0d", c), task_done, (c == 6) ? 1 : 0);
            if (c == 1) check("A_rs1_g0", alu_rs1, {32'd2, 32'd1});
            if (c == 4) check("A_rs1_g1", alu_rs1, {32'd4, 32'd3});
        end
        task_valid = 1'b0;
        check("A_rd", task_rd, p4(44, 33, 22, 11));
        step();
        check("A_idle", {task_done, alu_valid}, '0);

        // Staggered lanes, plus a stale lane-1 done with junk data once lane 1 has finished.
        lat[0] = 4;
        lat[1] = 1;
        present(0, p4(9, 8, 7, 6), p4(90, 80, 70, 60), p4(3, 3, 3, 3));
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c <= 6) check($sformatf("B_valid_c%0d", c), alu_valid, exp_vb[c-1]);
            check($sformatf("B_done_c%0d", c), task_done, (c == 12) ? 1 : 0);
            spur = (c == 3) ? 2'b10 : 2'b00;
        end
        spur = '0;
        task_valid = 1'b0;
        check("B_rd", task_rd, p4(102, 91, 80, 69));
        step();

        // Spurious done in IDLE, then in NEXT.
        saved = task_rd;
        spur = 2'b01;
        step();
        spur = '0;
        check("C_idle_rd", task_rd, saved);
        check("C_idle_ctrl", {task_done, alu_valid}, '0);
        step();
        check("C_idle_ctrl2", {task_done, alu_valid}, '0);
        lat[0] = 1;
        lat[1] = 1;
        present(2, p4(11, 12, 13, 14), p4(5, 6, 7, 8), '0);
        step();
        step();
        step();
        spur = 2'b01;
        step();
        spur = '0;
        check("C_next_valid", alu_valid, 2'b11);
        step();
        step();
        check("C_next_done", task_done, 1);
        task_valid = 1'b0;
        check("C_next_rd", task_rd, p4(18, 20, 22, 24));
        step();

        // Back-to-back: second task presented in the done cycle.
        present(0, p4(1, 2, 3, 4), p4(10, 20, 30, 40), '0);
        for (int c = 1; c <= 6; c++) step();
        check("D_done1", task_done, 1);
        check("D_rd1", task_rd, p4(11, 22, 33, 44));
        present(3, p4(100, 101, 102, 103), p4(7, 7, 7, 7), p4(1, 1, 1, 1));
        step();
        check("D_gap", task_done, 0);
        wait_done("D2", cyc);
        check("D_cycles2", cyc, 6);
        check("D_rd2", task_rd, p4(111, 112, 113, 114));
        step();

        // Reset in the middle of a task.
        present(0, p4(50, 60, 70, 80), p4(1, 1, 1, 1), '0);
        step();
        step();
        rst = 1'b1;
        task_valid = 1'b0;
        step();
        rst = 1'b0;
        check("E_ctrl", {task_done, alu_valid, alu_op}, '0);
        check("E_rd", task_rd, '0);
        check("E_rs12", {alu_rs1, alu_rs2}, '0);
        check("E_rs3", alu_rs3, '0);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (task_done !== 1'b0 || alu_valid !== '0) seen = 1'b1;
        end
        check("E_quiet", seen, 0);
        present(tbl[0].op, tbl[0].rs1, tbl[0].rs2, tbl[0].rs3);
        wait_done("E_after", cyc);
        check("E_after_cycles", cyc, 6);
        check("E_after_rd", task_rd, tbl[0].rd);
        step();

        // Operands change after the accept cycle.
        orig = p4(21, 22, 23, 24);
        present(1, orig, p4(2, 2, 2, 2), '0);
        step();
        task_rs1 = ~orig;
        check("F_rs1_g0", alu_rs1, orig[LW-1:0]);
        step();
        step();
        step();
        check("F_rs1_g1", alu_rs1, orig[WW-1:LW]);
        wait_done("F", cyc);
        check("F_rd", task_rd, ref_rd(1, orig, p4(2, 2, 2, 2), '0));
        step();

        // Random tasks against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [OPW-1:0] op;
            logic [WW-1:0]  a, b, c;
            op = OPW'($urandom());
            a = rnd_warp();
            b = rnd_warp();
            c = rnd_warp();
            for (int l = 0; l < LN; l++) lat[l] = int'($urandom_range(1, 4));
            present(op, a, b, c);
            wait_done($sformatf("R%0d", i), cyc);
            check($sformatf("R%0d_cycles", i), cyc, ref_cycles());
            check($sformatf("R%0d_rd", i), task_rd, ref_rd(op, a, b, c));
            step();
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
